// File: rtl/iob_cache_wb_pkg.sv
// Shared types for the cache write buffer: drain FSM states and depth helper.
// Write merging is enabled by defining IOB_CACHE_WB_MERGE_EN.
package iob_cache_wb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } wb_state_t;

  localparam int unsigned WB_DEPTH_LOG2_DEF = 2;

  function automatic int unsigned wb_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/iob_cache_wb_regfile.sv
// Write-buffer entry storage: one byte-maskable write port, one async read port.
// Part of the write buffer; merging (IOB_CACHE_WB_MERGE_EN) relies on the byte mask.
module iob_cache_wb_regfile
  import iob_cache_wb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  alloc,
  input  logic [DEPTH_LOG2-1:0] wsel,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic [DEPTH_LOG2-1:0] rsel,
  output logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata,
  output logic [DATA_W/8-1:0]   rstrb
);

  localparam int DEPTH = wb_depth(DEPTH_LOG2);
  localparam int NB    = DATA_W / 8;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [NB-1:0]     strb_mem [DEPTH];

  // strobe bits are written with the byte mask, so a merge yields old|new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
        strb_mem[i] <= '0;
      end
    end else if (we) begin
      if (alloc)
        addr_mem[wsel] <= waddr;
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          data_mem[wsel][b*8 +: 8] <= wdata[b*8 +: 8];
          strb_mem[wsel][b]        <= wstrb[b];
        end
      end
    end
  end

  assign raddr = addr_mem[rsel];
  assign rdata = data_mem[rsel];
  assign rstrb = strb_mem[rsel];

endmodule

// File: rtl/iob_cache_write_buffer.sv
// Cache write buffer: circular FIFO with a two-state drain FSM to the back end.
// Define IOB_CACHE_WB_MERGE_EN to merge same-address pushes into the tail entry.
module iob_cache_write_buffer
  import iob_cache_wb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = WB_DEPTH_LOG2_DEF
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  push_i,
  input  logic [ADDR_W-1:0]     push_addr_i,
  input  logic [DATA_W-1:0]     push_wdata_i,
  input  logic [DATA_W/8-1:0]   push_wstrb_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  output logic                  be_valid_o,
  output logic [ADDR_W-1:0]     be_addr_o,
  output logic [DATA_W-1:0]     be_wdata_o,
  output logic [DATA_W/8-1:0]   be_wstrb_o,
  input  logic                  be_ready_i
);

  localparam int DEPTH = wb_depth(DEPTH_LOG2);
  localparam int NB    = DATA_W / 8;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [LW-1:0]         level;
  logic [LW-1:0]         level_nxt;
  wb_state_t             state;
  logic                  be_valid;
  logic                  overflow;

  logic                  full;
  logic                  pop;
  logic                  merge;
  logic                  alloc;
  logic                  drop;
  logic [DEPTH_LOG2-1:0] wsel;
  logic [NB-1:0]         wbe;

  assign full = (level == DEPTH_L);
  assign pop  = cke_i & (state == ISSUE) & be_ready_i;

`ifdef IOB_CACHE_WB_MERGE_EN
  logic [ADDR_W-1:0] last_addr;

  // the head under issue must not change, so level 1 merges only when idle
  assign merge = cke_i & push_i & (push_addr_i == last_addr) &
                 ((level >= LW'(2)) |
                  ((level == LW'(1)) & (state == IDLE)));

  assign wsel = merge ? tail - DEPTH_LOG2'(1) : tail;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)
      last_addr <= '0;
    else if (alloc)
      last_addr <= push_addr_i;
  end
`else
  assign merge = 1'b0;
  assign wsel  = tail;
`endif

  assign alloc = cke_i & push_i & ~merge & (~full | pop);
  assign drop  = cke_i & push_i & ~merge & full & ~pop;
  assign wbe   = alloc ? '1 : push_wstrb_i;

  always_comb begin
    level_nxt = level;
    case ({alloc, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      head     <= '0;
      tail     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      be_valid <= 1'b0;
    end else if (cke_i) begin
      if (alloc)
        tail <= tail + DEPTH_LOG2'(1);
      if (pop)
        head <= head + DEPTH_LOG2'(1);
      level <= level_nxt;
      if (drop)
        overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (level != '0) begin
            state    <= ISSUE;
            be_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (pop && level_nxt == '0) begin
            state    <= IDLE;
            be_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  iob_cache_wb_regfile #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_regfile (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .we    (alloc | merge),
    .alloc (alloc),
    .wsel  (wsel),
    .wbe   (wbe),
    .waddr (push_addr_i),
    .wdata (push_wdata_i),
    .wstrb (push_wstrb_i),
    .rsel  (head),
    .raddr (be_addr_o),
    .rdata (be_wdata_o),
    .rstrb (be_wstrb_o)
  );

  assign full_o     = full;
  assign empty_o    = (level == '0);
  assign level_o    = level;
  assign overflow_o = overflow;
  assign be_valid_o = be_valid;

endmodule

// File: tb/tb_iob_cache_write_buffer.sv
// Bench for the cache write buffer: directed steps then random traffic
// against a queue-based reference model (merge-aware via IOB_CACHE_WB_MERGE_EN).
module tb_iob_cache_write_buffer;

  localparam int D = 4;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        cke_i;
  logic        push_i;
  logic [31:0] push_addr_i;
  logic [31:0] push_wdata_i;
  logic [3:0]  push_wstrb_i;
  logic        full_o;
  logic        empty_o;
  logic [2:0]  level_o;
  logic        overflow_o;
  logic        be_valid_o;
  logic [31:0] be_addr_o;
  logic [31:0] be_wdata_o;
  logic [3:0]  be_wstrb_o;
  logic        be_ready_i;

  iob_cache_write_buffer dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .cke_i        (cke_i),
    .push_i       (push_i),
    .push_addr_i  (push_addr_i),
    .push_wdata_i (push_wdata_i),
    .push_wstrb_i (push_wstrb_i),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .be_valid_o   (be_valid_o),
    .be_addr_o    (be_addr_o),
    .be_wdata_o   (be_wdata_o),
    .be_wstrb_o   (be_wstrb_o),
    .be_ready_i   (be_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t mq[$];
  bit   mv;
  bit   movf;
  int   vectors;
  int   miscompares;

`ifdef IOB_CACHE_WB_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: queue of entries plus a "request outstanding" flag
  task automatic model_edge();
    int   n;
    bit   pop, mrg, acc, drop;
    ent_t e;
    n    = mq.size();
    pop  = cke_i && mv && be_ready_i;
    mrg  = MERGE && cke_i && push_i && n > 0 &&
           mq[n-1].a == push_addr_i && (n >= 2 || !mv);
    acc  = cke_i && push_i && !mrg && (n < D || pop);
    drop = cke_i && push_i && !mrg && !acc;
    if (mrg) begin
      e = mq[n-1];
      for (int b = 0; b < 4; b++)
        if (push_wstrb_i[b]) begin
          e.d[b*8 +: 8] = push_wdata_i[b*8 +: 8];
          e.s[b] = 1'b1;
        end
      mq[n-1] = e;
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{push_addr_i, push_wdata_i, push_wstrb_i});
    if (drop) movf = 1'b1;
    if (cke_i) mv = mv ? (pop ? (mq.size() > 0) : 1'b1) : (n > 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, level_o, mq.size());
    chk({tag, ".empty"}, empty_o, mq.size() == 0);
    chk({tag, ".full"}, full_o, mq.size() == D);
    chk({tag, ".ovf"}, overflow_o, movf);
    chk({tag, ".valid"}, be_valid_o, mv);
    if (mq.size() > 0) begin
      chk({tag, ".addr"}, be_addr_o, mq[0].a);
      chk({tag, ".data"}, be_wdata_o, mq[0].d);
      chk({tag, ".strb"}, be_wstrb_o, mq[0].s);
    end
  endtask

  task automatic step(input string tag, input logic p, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic r, input logic c);
    push_i = p; push_addr_i = a; push_wdata_i = d; push_wstrb_i = s;
    be_ready_i = r; cke_i = c;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    arst_n_i = 1'b0;
    #1;
    mq.delete();
    mv = 1'b0;
    movf = 1'b0;
    check_all(tag);
    chk({tag, ".raddr"}, be_addr_o, 0);
    chk({tag, ".rdata"}, be_wdata_o, 0);
    chk({tag, ".rstrb"}, be_wstrb_o, 0);
    #2;
    arst_n_i = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    cke_i = 1'b1; push_i = 1'b0; push_addr_i = '0; push_wdata_i = '0;
    push_wstrb_i = '0; be_ready_i = 1'b0; arst_n_i = 1'b1;
    #1;
    do_reset("rst0");

    // single push latency
    step("lat1", 1, 32'h100, 32'h11223344, 4'hF, 1, 1);
    chk("lat1.v", be_valid_o, 0);
    step("lat2", 0, 0, 0, 0, 1, 1);
    chk("lat2.v", be_valid_o, 1);
    chk("lat2.a", be_addr_o, 32'h100);
    step("lat3", 0, 0, 0, 0, 1, 1);
    chk("lat3.v", be_valid_o, 0);
    chk("lat3.e", empty_o, 1);

    // fill, overflow, drain in order
    do_reset("rst1");
    for (int i = 0; i < 4; i++)
      step("fill", 1, 32'h200 + i * 4, 32'hA0 + i, 4'hF, 0, 1);
    chk("fill.full", full_o, 1);
    chk("fill.lvl", level_o, 4);
    step("ovf", 1, 32'h300, 32'hDEAD, 4'hF, 0, 1);
    chk("ovf.o", overflow_o, 1);
    chk("ovf.lvl", level_o, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain.v", be_valid_o, 1);
      chk("drain.a", be_addr_o, 32'h200 + i * 4);
      step("drain", 0, 0, 0, 0, 1, 1);
    end
    chk("drain.e", empty_o, 1);

    // push and pop together at full
    do_reset("rst2");
    for (int i = 0; i < 4; i++)
      step("fill2", 1, 32'h400 + i * 4, 32'hB0 + i, 4'hF, 0, 1);
    step("pp", 1, 32'h440, 32'hCAFE, 4'h5, 1, 1);
    chk("pp.lvl", level_o, 4);
    chk("pp.ovf", overflow_o, 0);

    // merging into the tail entry
    do_reset("rst3");
    step("m0", 1, 32'h500, 32'h55, 4'hF, 0, 1);
    step("m1", 1, 32'h504, 32'h99, 4'h1, 0, 1);
    step("m2", 1, 32'h504, 32'hAABBCCDD, 4'h3, 0, 1);
    step("m3", 1, 32'h504, 32'h11223344, 4'hC, 0, 1);
    chk("m.lvl", level_o, MERGE ? 2 : 4);
    step("m4", 0, 0, 0, 0, 1, 1);
    chk("m.a", be_addr_o, 32'h504);
    chk("m.d", be_wdata_o, MERGE ? 32'h1122CCDD : 32'h99);
    chk("m.s", be_wstrb_o, MERGE ? 4'hF : 4'h1);

    // reset while a request is pending
    do_reset("rst4");
    step("ri0", 1, 32'h700, 32'h77, 4'hF, 0, 1);
    step("ri1", 0, 0, 0, 0, 0, 1);
    chk("ri.v", be_valid_o, 1);
    #3;
    do_reset("ri.rst");
    step("ri2", 0, 0, 0, 0, 1, 1);
    step("ri3", 0, 0, 0, 0, 1, 1);
    chk("ri.v2", be_valid_o, 0);

    // clock enable low freezes everything
    do_reset("rst5");
    step("ck0", 1, 32'h800, 32'h1, 4'hF, 0, 1);
    step("ck1", 1, 32'h804, 32'h2, 4'hF, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("cke", 1, 32'h808, 32'h3, 4'hF, 1, 0);
      chk("cke.lvl", level_o, 2);
      chk("cke.v", be_valid_o, 1);
    end

    // random traffic
    do_reset("rst6");
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd.rst");
      end else begin
        step("rnd", 1'($urandom_range(0, 9) < 6),
             32'h600 + 4 * $urandom_range(0, 2), $urandom,
             4'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_cache_write_buffer.md
IOB_CACHE_WRITE_BUFFER -- requirements
Module: iob_cache_write_buffer

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, byte-address width; DATA_W, default 32, data width (multiple of 8); DEPTH_LOG2, default 2, log2 of entry count (DEPTH=2**DEPTH_LOG2, DEPTH_LOG2>=1).
REQ-002 Clocking SHALL be a single clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, in order:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; all state holds when 0
- push_i  in  1  write request from the cache-memory stage (registered front-end request)
- push_addr_i  in  ADDR_W  write address
- push_wdata_i  in  DATA_W  write data
- push_wstrb_i  in  DATA_W/8  byte strobes
- full_o  out  1  level==DEPTH
- empty_o  out  1  level==0
- level_o  out  DEPTH_LOG2+1  occupied entries
- overflow_o  out  1  sticky: push dropped
- be_valid_o  out  1  back-end write request
- be_addr_o  out  ADDR_W  head address
- be_wdata_o  out  DATA_W  head data
- be_wstrb_o  out  DATA_W/8  head strobes
- be_ready_i  in  1  back-end accepts when be_valid_o & be_ready_i

Function
REQ-004 Storage SHALL be a circular FIFO of DEPTH entries {addr,wdata,wstrb} with head/tail pointers wrapping modulo DEPTH.
REQ-005 A push SHALL be accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- Accepted push writes to the tail.
- Level changes by +1 on push only, -1 on pop only, 0 on simultaneous push and pop.
REQ-006 A push with level==DEPTH and no same-cycle pop SHALL be dropped and SHALL set overflow_o, which stays 1 until reset.
REQ-007 The drain FSM SHALL have two states:
- IDLE: be_valid_o=0.
- ISSUE: be_valid_o=1.
REQ-008 FSM transitions SHALL be:
- IDLE->ISSUE when level>0.
- In ISSUE, be_ready_i=1 pops the head; stay in ISSUE if post-pop level>0, else go to IDLE.
- In ISSUE, be_ready_i=0 holds state.
REQ-009 be_addr_o, be_wdata_o and be_wstrb_o SHALL reflect the head entry combinationally and SHALL remain stable while be_valid_o=1 and be_ready_i=0.
REQ-010 Latency SHALL be: a push accepted at edge t into an empty buffer raises be_valid_o after edge t+1. Consecutive entries issue back-to-back with no idle cycle.
REQ-011 full_o, empty_o and level_o SHALL be decoded from registered level only.
REQ-012 With cke_i=0, pushes, pops, FSM and overflow_o SHALL all hold.

Reset
REQ-013 Asserting arst_n_i=0 SHALL immediately force the following, regardless of clock, and discard all contents:
- pointers=0, level_o=0, empty_o=1, full_o=0, overflow_o=0
- state=IDLE, be_valid_o=0
- storage=0, so be_addr_o/be_wdata_o/be_wstrb_o=0
REQ-014 A reset during ISSUE SHALL abandon the pending request; no pop is counted.

Configuration
REQ-015 Macro IOB_CACHE_WB_MERGE_EN SHALL enable write merging.
- A push SHALL merge into the tail-most entry when all of the following hold:
  - the push address equals that entry's address;
  - level>=2, or level==1 and state==IDLE.
- On merge, bytes with push_wstrb_i set are overwritten, the stored wstrb becomes old|new, and level is unchanged.
- A merge is accepted even when full.
REQ-016 Without IOB_CACHE_WB_MERGE_EN, every accepted push SHALL allocate a new entry; no address comparator is instantiated.

Structure
REQ-017 Package iob_cache_wb_pkg SHALL hold the FSM state encoding (IDLE=0, ISSUE=1) and the DEPTH derivation constant.
REQ-018 Storage SHALL be the single sub-module iob_cache_wb_regfile:
- 1 write port and 1 asynchronous read port;
- a per-byte write enable for merging;
- asynchronous active-low reset to zero.

Verification
REQ-019 The bench SHALL cover:
- Push A=0x100 D=0x11223344 S=0xF into empty buffer, be_ready_i=1 -> be_valid_o=1 exactly 2 edges after push, 1-cycle pulse, be_addr_o=0x100, empty_o=1 afterwards.
- Push 4 distinct entries with be_ready_i=0 (DEPTH=4) -> full_o=1, level_o=4; 5th push -> overflow_o=1, level_o=4; then be_ready_i=1 -> 4 consecutive back-to-back pops in order.
- At full, push and pop in the same cycle -> push accepted, level_o stays 4, overflow_o=0.
- MERGE_EN, level==2, push to tail address S=0x3 then S=0xC -> level_o stays 2, tail wstrb=0xF with both byte halves updated; MERGE_EN undefined -> level_o=4.
- Assert arst_n_i mid-ISSUE with be_ready_i=0 -> be_valid_o=0 and level_o=0 before the next edge; no transaction completes.
- cke_i=0 for 3 cycles with push_i=1 and be_ready_i=1 -> level_o and be_valid_o unchanged.
